// File: rtl/packet_decoder.sv
// packet_decoder: UART frame decoder; finds HEADER, collects DATA_BIT-wide
// output/freq patterns plus a control byte (LSB byte first), validates them and
// publishes held fields with a one-hot channel load strobe. Optional macro
// CHECKSUM_EN adds a trailing XOR checksum byte (S_CHK state).
// Ports: clk, rst_n (async, active-low); i_data/i_rx_done_tick byte input;
// o_output_pattern, o_freq_pattern, o_sel_out, o_start, o_stop, o_mode held fields;
// o_chan_load/o_done_tick good-frame pulses; o_err_tick/o_err_code error report
// (01 timeout, 10 checksum, 11 bad channel); o_busy high outside S_IDLE.
module packet_decoder #(
  parameter int DATA_BIT = 32,
  parameter int CHANNEL_NUM = 4,
  parameter logic [7:0] HEADER = 8'hA5,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             i_data,
  input  logic                   i_rx_done_tick,
  output logic [DATA_BIT-1:0]    o_output_pattern,
  output logic [DATA_BIT-1:0]    o_freq_pattern,
  output logic [3:0]             o_sel_out,
  output logic                   o_start,
  output logic                   o_stop,
  output logic                   o_mode,
  output logic [CHANNEL_NUM-1:0] o_chan_load,
  output logic                   o_done_tick,
  output logic                   o_err_tick,
  output logic [1:0]             o_err_code,
  output logic                   o_busy
);
  localparam int PAY_NUM = 2*DATA_BIT/8 + 1;
  localparam int BW = PAY_NUM*8;
  localparam int CW = $clog2(PAY_NUM+1);
  localparam int TW = $clog2(TIMEOUT_CYC+1);
  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA
`ifdef CHECKSUM_EN
    , S_CHK
`endif
  } state_t;
  state_t state;
  logic [BW-1:0] buffer, nxt, fr;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic last, fin, sum_ok, sel_ok;
  assign nxt = {i_data, buffer[BW-1:8]};
  assign last = state == S_DATA && cnt == CW'(PAY_NUM-1);
`ifdef CHECKSUM_EN
  logic [7:0] xacc;
  // the last payload byte is already in the buffer when the checksum byte arrives
  assign fr = buffer;
  assign sum_ok = i_data == xacc;
  assign fin = i_rx_done_tick && state == S_CHK;
`else
  // no checksum byte: validate the frame as the last payload byte is shifted in
  assign fr = nxt;
  assign sum_ok = 1'b1;
  assign fin = i_rx_done_tick && last;
`endif
  assign sel_ok = {1'b0, fr[BW-1 -: 4]} < 5'(CHANNEL_NUM);
  assign o_busy = state != S_IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      buffer <= '0;
      cnt <= '0;
      tcnt <= '0;
`ifdef CHECKSUM_EN
      xacc <= '0;
`endif
      o_output_pattern <= '0;
      o_freq_pattern <= '0;
      o_sel_out <= '0;
      o_start <= 1'b0;
      o_stop <= 1'b0;
      o_mode <= 1'b0;
      o_chan_load <= '0;
      o_done_tick <= 1'b0;
      o_err_tick <= 1'b0;
      o_err_code <= '0;
    end else begin
      o_done_tick <= 1'b0;
      o_err_tick <= 1'b0;
      o_chan_load <= '0;
      if (state == S_IDLE) begin
        if (i_rx_done_tick && i_data == HEADER) begin
          state <= S_DATA;
          cnt <= '0;
          tcnt <= '0;
`ifdef CHECKSUM_EN
          xacc <= '0;
`endif
        end
      end else if (i_rx_done_tick) begin
        tcnt <= '0;
        if (state == S_DATA) begin
          buffer <= nxt;
          cnt <= cnt + 1'b1;
`ifdef CHECKSUM_EN
          xacc <= xacc ^ i_data;
          if (last) state <= S_CHK;
`endif
        end
        if (fin) begin
          state <= S_IDLE;
          if (!sum_ok || !sel_ok) begin
            o_err_tick <= 1'b1;
            o_err_code <= sum_ok ? 2'b11 : 2'b10;
          end else begin
            o_done_tick <= 1'b1;
            o_output_pattern <= fr[DATA_BIT-1:0];
            o_freq_pattern <= fr[2*DATA_BIT-1:DATA_BIT];
            o_start <= fr[BW-8];
            o_stop <= fr[BW-7];
            o_mode <= fr[BW-6];
            o_sel_out <= fr[BW-1 -: 4];
            o_chan_load <= CHANNEL_NUM'(1) << fr[BW-1 -: 4];
          end
        end
      end else begin
        // incrementing past the limit cannot wrap: the frame is dropped at the limit
        tcnt <= tcnt + 1'b1;
        if (tcnt == TW'(TIMEOUT_CYC-1)) begin
          state <= S_IDLE;
          o_err_tick <= 1'b1;
          o_err_code <= 2'b01;
        end
      end
    end
  end
endmodule

// File: tb/tb_packet_decoder.sv
// tb_packet_decoder: directed self-checking bench for packet_decoder
module tb_packet_decoder;
  localparam int TO = 20;
  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0;
  logic [7:0] data = 8'h00;
  logic [31:0] op, fp;
  logic [3:0] sel, load;
  logic start, stop, mode, done, err, busy;
  logic [1:0] code;
  int errs = 0, checks = 0, n;
  packet_decoder #(.DATA_BIT(32), .CHANNEL_NUM(4), .HEADER(8'hA5), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .i_data(data), .i_rx_done_tick(tick),
    .o_output_pattern(op), .o_freq_pattern(fp), .o_sel_out(sel), .o_start(start),
    .o_stop(stop), .o_mode(mode), .o_chan_load(load), .o_done_tick(done),
    .o_err_tick(err), .o_err_code(code), .o_busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    data = b;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask
  task automatic frame(input logic [31:0] o, input logic [31:0] f, input logic [7:0] ctl, input logic [7:0] chk);
    send(8'hA5);
    for (int i = 0; i < 4; i++) send(o[8*i +: 8]);
    for (int i = 0; i < 4; i++) send(f[8*i +: 8]);
    send(ctl);
`ifdef CHECKSUM_EN
    send(chk);
`endif
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_op", op, 0);
    check("rst_fp", fp, 0);
    check("rst_flags", {sel, start, stop, mode, load, done, err, code, busy}, 0);
    rst_n = 1'b1;
    send(8'h00);
    send(8'hFF);
    check("junk_busy", busy, 0);
    frame(32'h12345678, 32'hDEADBEEF, 8'h35, 8'h1F);
    check("good_op", op, 64'h12345678);
    check("good_fp", fp, 64'hDEADBEEF);
    check("good_flags", {start, stop, mode}, 3'b101);
    check("good_sel", sel, 3);
    check("good_load", load, 4'b1000);
    check("good_ticks", {done, err, busy}, 3'b100);
    @(negedge clk);
    check("good_done_end", {done, load}, 0);
    check("good_hold", op, 64'h12345678);
    frame(32'h12345678, 32'hDEADBEEF, 8'h02, 8'h28);
    check("sel0_flags", {start, stop, mode, sel}, {3'b010, 4'd0});
    check("sel0_load", {load, done}, {4'b0001, 1'b1});
`ifdef CHECKSUM_EN
    frame(32'h11111111, 32'h22222222, 8'h35, 8'h00);
    check("badsum_ticks", {err, done, load}, {1'b1, 1'b0, 4'b0});
    check("badsum_code", code, 2'b10);
    check("badsum_hold", {op, fp}, {32'h12345678, 32'hDEADBEEF});
`endif
    frame(32'h12345678, 32'hDEADBEEF, 8'h55, 8'h7F);
    check("badch_ticks", {err, done, load}, {1'b1, 1'b0, 4'b0});
    check("badch_code", code, 2'b11);
    check("badch_hold", {start, stop, mode, sel}, {3'b010, 4'd0});
    send(8'hA5);
    send(8'h78);
    send(8'h56);
    check("to_busy", busy, 1);
    n = 0;
    for (int i = 1; i <= 3*TO; i++) begin
      @(negedge clk);
      if (err) begin
        n = i;
        break;
      end
    end
    check("to_cycles", n, TO);
    check("to_code", code, 2'b01);
    check("to_busy_low", {busy, done}, 0);
    frame(32'h123456A5, 32'hDEADBEEF, 8'h35, 8'hC2);
    check("a5_op", op, 64'h123456A5);
    check("a5_done", {done, err, load}, {2'b10, 4'b1000});
    send(8'hA5);
    for (int i = 0; i < 4; i++) send(8'h11);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_pat", {op, fp}, 0);
    check("mrst_flags", {sel, start, stop, mode, load, done, err, code, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mrst_quiet", {done, err, busy}, 0);
    frame(32'h12345678, 32'hDEADBEEF, 8'h35, 8'h1F);
    check("mrst_op", {op, fp}, {32'h12345678, 32'hDEADBEEF});
    check("mrst_load", {load, done, sel}, {4'b1000, 1'b1, 4'd3});
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/packet_decoder.md
Name: packet_decoder

Overview:
- Parametrised successor to the single-frame UART decoder. Consumes received UART bytes and hunts for a header byte. Collects a fixed-length little-endian payload and validates it: inter-byte timeout, optional XOR checksum, channel range.
- On a good frame, publishes registered, held pattern/control fields plus a one-hot per-channel load strobe to the serial-out channel bank.
- Bad frames raise a coded error tick.

Parameters:
- DATA_BIT, 32, pattern width; multiple of 8, range 8..64.
- CHANNEL_NUM, 4, number of serial-out channels; range 1..16.
- HEADER, 8'hA5, frame start byte.
- TIMEOUT_CYC, 50000, max clk cycles between bytes inside a frame; must be at least 1.
- Derived localparam PAY_NUM = 2*DATA_BIT/8 + 1, the payload bytes.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- i_data  input  8  received UART byte.
- i_rx_done_tick  input  1  one-cycle strobe; i_data valid.
- o_output_pattern  output  DATA_BIT  output pattern of last good frame.
- o_freq_pattern  output  DATA_BIT  frequency pattern of last good frame.
- o_sel_out  output  4  channel index of last good frame.
- o_start  output  1  start flag.
- o_stop  output  1  stop flag.
- o_mode  output  1  mode flag.
- o_chan_load  output  CHANNEL_NUM  one-hot load pulse, coincident with o_done_tick.
- o_done_tick  output  1  one-cycle good-frame strobe.
- o_err_tick  output  1  one-cycle bad-frame strobe.
- o_err_code  output  2  01 timeout, 10 checksum, 11 bad channel; held until next error.
- o_busy  output  1  high while not in S_IDLE.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset: all outputs 0, state S_IDLE, buffer 0, byte counter 0, timeout counter 0.
- Frame format: HEADER, then PAY_NUM payload bytes, then a checksum byte (only with CHECKSUM_EN). Payload is LSB byte first.
  - Bytes 0..DATA_BIT/8-1 form the output pattern.
  - The next DATA_BIT/8 bytes form the freq pattern.
  - The last payload byte is control: bit0 start, bit1 stop, bit2 mode, bit3 ignored, bits7:4 sel.
- FSM states S_IDLE, S_DATA, S_CHK.
- S_IDLE:
  - A tick with i_data==HEADER goes to S_DATA and clears the byte counter, timeout counter and running XOR.
  - Any other byte is discarded.
- S_DATA:
  - Each tick right-shifts the byte into the buffer MSB, increments the counter and XORs the byte into the checksum accumulator.
  - A HEADER value here is ordinary data.
  - On the PAY_NUM-th byte: with CHECKSUM_EN go to S_CHK; otherwise perform frame validation in that same cycle.
- S_CHK: the next tick compares i_data with the accumulated XOR, then performs frame validation.
- Frame validation:
  - Checksum mismatch gives code 10.
  - Otherwise sel >= CHANNEL_NUM gives code 11.
  - Otherwise the frame is good.
  - The FSM returns to S_IDLE in all cases.
- Latency: outputs update at the clock edge that samples the final byte's tick. o_done_tick and o_chan_load[sel] are high for exactly the following cycle.
- Held outputs:
  - Pattern/flag/sel outputs hold until the next good frame. Error frames do not disturb them.
  - o_chan_load is 0 except during the done cycle.
- Timeout:
  - In S_DATA/S_CHK the counter increments on every cycle without a tick and clears on each tick.
  - On reaching TIMEOUT_CYC: o_err_tick with code 01, return to S_IDLE, and the partial frame is dropped.
  - If a tick arrives in the same cycle the limit would be hit, the byte wins and no timeout occurs.
  - The counter saturates and never wraps. Its width is $clog2(TIMEOUT_CYC+1).
- o_done_tick and o_err_tick are never high together.
- A byte tick in the cycle immediately after frame completion is handled by S_IDLE normally, so back-to-back frames are supported.
- Reset asserted mid-frame aborts the frame with no tick.

Optional Feature:
- Macro: CHECKSUM_EN.
- Defined: S_CHK exists and a trailing checksum byte is required. It is the XOR of all payload bytes, excluding the header. A mismatch gives o_err_tick with code 10.
- Undefined: S_CHK and the XOR logic are removed. The frame ends on the last payload byte, and code 10 never occurs.

Test Plan:
- All scenarios use defaults, DATA_BIT=32, CHANNEL_NUM=4, with CHECKSUM_EN defined.
- Good frame: send A5 78 56 34 12 EF BE AD DE 35 1F. Required: o_output_pattern=32'h12345678, o_freq_pattern=32'hDEADBEEF, start=1, stop=0, mode=1, sel=3, o_chan_load=4'b1000, and a one-cycle o_done_tick after the 1F tick.
- Bad checksum: same frame ending 00 instead of 1F. Required: o_err_tick with code 10, no done, outputs keep their previous values.
- Bad channel: control 55, checksum 7F. Required: o_err_tick with code 11, o_chan_load stays 0.
- Timeout: send A5 78 56, then idle TIMEOUT_CYC cycles. Required: o_err_tick with code 01, o_busy falls. A following good frame decodes correctly.
- Sync: send 00 FF then the good frame. Junk is ignored and the frame decodes. A5 inside the payload (byte0=A5) is decoded as data.
- Reset mid-frame: assert rst_n low after 4 payload bytes. Required: all outputs 0, no ticks; the next good frame decodes.
